dma_burst_seq: RTL and testbench
================================

DMA_BURST_SEQ -- requirements
Module: dma_burst_seq

Interface
REQ-001 SHALL have parameter CSR_ADDR_WIDTH, default 8, CSR address width.
REQ-002 SHALL have parameter CSR_DATA_WIDTH, default 32, CSR data width.
REQ-003 SHALL have ports, in this order:
- clk  in  1  sole clock; one clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- csr_addr  in  CSR_ADDR_WIDTH  CSR address.
- csr_wen  in  1  one-cycle write strobe.
- csr_ren  in  1  one-cycle read strobe; informational, no side effects.
- csr_wdata  in  CSR_DATA_WIDTH  write data.
- csr_rdata  out  CSR_DATA_WIDTH  combinational read of the register at csr_addr; unmapped addresses read 0.
- burst_valid  out  1  burst request valid.
- burst_ready  in  1  engine accepts the request.
- burst_layer  out  8  layer index.
- burst_offset  out  16  beat offset of this burst.
- burst_len  out  8  beats in this burst, 1..255.
- burst_done  in  1  one-cycle pulse when the accepted burst completes.
- irq  out  1  level interrupt.

Function
REQ-004 Register map:
- 0x50 LAYER: RW [7:0].
- 0x51 CTRL: bit0 START (W1, self-clearing, reads 0); bit1 ABORT (W1, reads 0); bit2 IRQ_EN (RW).
- 0x52 COUNT: RW [15:0], total beats.
- 0x53 STATUS: bit0 BUSY (RO); bit1 DONE (W1C); bit2 ERR (W1C); [31:16] remaining beats (RO).
- 0x54 BURST: RW [7:0], maximum beats per burst.
REQ-005 SHALL ignore writes to LAYER, COUNT and BURST while BUSY=1.
REQ-006 SHALL implement the FSM states IDLE, ISSUE, WAIT and DRAIN; BUSY=1 in every state except IDLE.
REQ-007 IDLE + START: if COUNT==0 or BURST==0, SHALL set ERR and stay IDLE; otherwise, on the next cycle, SHALL load remaining=COUNT and offset=0, clear DONE and ERR, and enter ISSUE.
REQ-008 ISSUE: burst_valid=1 with burst_len=min(remaining, BURST); outputs SHALL hold stable until burst_ready; the handshake cycle SHALL enter WAIT.
REQ-009 WAIT + burst_done: remaining-=burst_len and offset+=burst_len; if the new remaining==0, SHALL go to IDLE and set DONE; else go to ISSUE on the next cycle.
REQ-010 offset SHALL wrap modulo 2^16 without error.
REQ-011 ABORT in ISSUE SHALL go to IDLE next cycle with ERR set; burst_valid SHALL drop.
REQ-012 ABORT in WAIT SHALL go to DRAIN; DRAIN + burst_done SHALL go to IDLE with ERR set.
REQ-013 ABORT while IDLE SHALL be ignored.
REQ-014 START while BUSY SHALL be ignored.
REQ-015 START and ABORT in the same write SHALL be treated as ABORT only.
REQ-016 burst_done outside WAIT/DRAIN SHALL be ignored.
REQ-017 W1C of DONE or ERR in the same cycle the FSM sets that bit SHALL leave the bit set (set wins).

Reset
REQ-018 rst_n low SHALL force state IDLE and clear all registers, remaining and offset.
REQ-019 During reset: burst_valid=0, burst_layer=0, burst_offset=0, burst_len=0, irq=0, csr_rdata=0 for every address.
REQ-020 Reset asserted mid-transfer SHALL abandon the transfer; no burst_done is expected afterward.

Configuration
REQ-021 With DMA_SEQ_IRQ_EN defined: irq = IRQ_EN & (DONE | ERR).
REQ-022 Without DMA_SEQ_IRQ_EN: irq SHALL be tied 0, the IRQ_EN bit SHALL be unimplemented (reads 0), and all other behaviour SHALL be unchanged.

Structure
REQ-023 Package dma_seq_pkg SHALL hold the CSR address localparams 0x50..0x54, the CTRL/STATUS bit-position constants and the FSM state enum.
REQ-024 SHALL be a single module; no sub-module.

Verification
REQ-025 LAYER=3, COUNT=10, BURST=4, START -> three bursts, len/offset 4/0, 4/4, 2/8, then DONE=1 and BUSY=0.
REQ-026 COUNT=0, START -> ERR=1, BUSY=0, no burst_valid.
REQ-027 burst_ready held low for 5 cycles -> burst_valid, burst_layer, burst_offset and burst_len stable for all 5 cycles.
REQ-028 ABORT during WAIT -> stays BUSY until burst_done, then IDLE with ERR=1; remaining reflects the one completed burst.
REQ-029 COUNT write 0x20 while BUSY -> readback unchanged.
REQ-030 With DMA_SEQ_IRQ_EN and IRQ_EN=1, DONE -> irq=1; W1C DONE -> irq=0 next cycle.
REQ-031 rst_n low mid-ISSUE -> all outputs 0 and state IDLE immediately (asynchronous).

Source files
------------

// File: rtl/dma_seq_pkg.sv
// Shared definitions for the DMA burst sequencer: CSR map, CTRL/STATUS bit
// positions, FSM state encoding and the burst-length helper.
package dma_seq_pkg;

    localparam logic [7:0] ADDR_LAYER  = 8'h50;
    localparam logic [7:0] ADDR_CTRL   = 8'h51;
    localparam logic [7:0] ADDR_COUNT  = 8'h52;
    localparam logic [7:0] ADDR_STATUS = 8'h53;
    localparam logic [7:0] ADDR_BURST  = 8'h54;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_ABORT_BIT  = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;

    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DONE_BIT = 1;
    localparam int STAT_ERR_BIT  = 2;
    localparam int STAT_REM_LSB  = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } seq_state_t;

    // Length of the next burst: the smaller of beats left and the burst cap.
    function automatic logic [7:0] burst_min(input logic [15:0] rem,
                                             input logic [7:0]  max_len);
        if (rem < {8'h00, max_len}) return rem[7:0];
        else                        return max_len;
    endfunction

endpackage

// File: rtl/dma_burst_seq.sv
// DMA burst sequencer: splits a COUNT-beat transfer into bursts of at most
// BURST beats, handshakes each with the engine and reports DONE/ERR.
// Optional feature macro: DMA_SEQ_IRQ_EN (level interrupt and CTRL.IRQ_EN).
module dma_burst_seq
    import dma_seq_pkg::*;
#(
    parameter int CSR_ADDR_WIDTH = 8,
    parameter int CSR_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_addr,
    input  logic                      csr_wen,
    input  logic                      csr_ren,
    input  logic [CSR_DATA_WIDTH-1:0] csr_wdata,
    output logic [CSR_DATA_WIDTH-1:0] csr_rdata,
    output logic                      burst_valid,
    input  logic                      burst_ready,
    output logic [7:0]                burst_layer,
    output logic [15:0]               burst_offset,
    output logic [7:0]                burst_len,
    input  logic                      burst_done,
    output logic                      irq
);

    seq_state_t  r_state;
    logic [7:0]  r_layer;
    logic [15:0] r_count;
    logic [7:0]  r_burst;
    logic        r_done;
    logic        r_err;
    logic [15:0] r_remaining;
    logic [15:0] r_offset;
    logic        r_bvalid;
    logic [7:0]  r_blayer;
    logic [15:0] r_boff;
    logic [7:0]  r_blen;

    logic        w_busy;
    logic        w_sel_layer, w_sel_ctrl, w_sel_count, w_sel_status, w_sel_burst;
    logic        w_start, w_abort, w_start_ok;
    logic        w_w1c_done, w_w1c_err;
    logic        w_set_done, w_set_err, w_clr_status;
    logic [15:0] w_new_rem, w_new_off;
    logic        w_irq_en;
    logic [31:0] w_rdata32;
    logic        w_unused;

    assign w_busy       = (r_state != S_IDLE);
    assign w_sel_layer  = (csr_addr == CSR_ADDR_WIDTH'(ADDR_LAYER));
    assign w_sel_ctrl   = (csr_addr == CSR_ADDR_WIDTH'(ADDR_CTRL));
    assign w_sel_count  = (csr_addr == CSR_ADDR_WIDTH'(ADDR_COUNT));
    assign w_sel_status = (csr_addr == CSR_ADDR_WIDTH'(ADDR_STATUS));
    assign w_sel_burst  = (csr_addr == CSR_ADDR_WIDTH'(ADDR_BURST));

    // ABORT in the same write as START suppresses the START.
    assign w_abort    = csr_wen & w_sel_ctrl & csr_wdata[CTRL_ABORT_BIT];
    assign w_start    = csr_wen & w_sel_ctrl & csr_wdata[CTRL_START_BIT] & ~w_abort;
    assign w_start_ok = w_start & (r_count != '0) & (r_burst != '0);
    assign w_w1c_done = csr_wen & w_sel_status & csr_wdata[STAT_DONE_BIT];
    assign w_w1c_err  = csr_wen & w_sel_status & csr_wdata[STAT_ERR_BIT];

    assign w_new_rem = r_remaining - {8'h00, r_blen};
    assign w_new_off = r_offset + {8'h00, r_blen};

    // csr_ren is informational only; upper write-data bits have no home.
    assign w_unused = ^{csr_ren, csr_wdata};

    // Status-bit events raised by the sequencer this cycle.
    always_comb begin
        w_set_done   = 1'b0;
        w_set_err    = 1'b0;
        w_clr_status = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start && !w_start_ok) w_set_err    = 1'b1;
                if (w_start_ok)             w_clr_status = 1'b1;
            end
            S_ISSUE: begin
                if (w_abort && !burst_ready) w_set_err = 1'b1;
            end
            S_WAIT: begin
                if (burst_done) begin
                    if (w_new_rem == '0) w_set_done = 1'b1;
                    else if (w_abort)    w_set_err  = 1'b1;
                end
            end
            S_DRAIN: begin
                if (burst_done) w_set_err = 1'b1;
            end
            default: ;
        endcase
    end

    // Configuration registers; LAYER/COUNT/BURST are frozen while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_layer <= '0;
            r_count <= '0;
            r_burst <= '0;
        end else if (csr_wen && !w_busy) begin
            if (w_sel_layer) r_layer <= csr_wdata[7:0];
            if (w_sel_count) r_count <= csr_wdata[15:0];
            if (w_sel_burst) r_burst <= csr_wdata[7:0];
        end
    end

    // DONE/ERR sticky flags; a set from the sequencer beats a same-cycle W1C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_set_done)                    r_done <= 1'b1;
            else if (w_clr_status || w_w1c_done) r_done <= 1'b0;
            if (w_set_err)                     r_err  <= 1'b1;
            else if (w_clr_status || w_w1c_err)  r_err  <= 1'b0;
        end
    end

    // Burst sequencer FSM with registered request outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_offset    <= '0;
            r_bvalid    <= 1'b0;
            r_blayer    <= '0;
            r_boff      <= '0;
            r_blen      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_state     <= S_ISSUE;
                        r_remaining <= r_count;
                        r_offset    <= '0;
                        r_bvalid    <= 1'b1;
                        r_blayer    <= r_layer;
                        r_boff      <= '0;
                        r_blen      <= burst_min(r_count, r_burst);
                    end
                end
                S_ISSUE: begin
                    // An accepted request must still see its burst_done, so a
                    // handshake coinciding with ABORT drains instead of dropping.
                    if (burst_ready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= w_abort ? S_DRAIN : S_WAIT;
                    end else if (w_abort) begin
                        r_state  <= S_IDLE;
                        r_bvalid <= 1'b0;
                        r_blayer <= '0;
                        r_boff   <= '0;
                        r_blen   <= '0;
                    end
                end
                S_WAIT: begin
                    if (burst_done) begin
                        r_remaining <= w_new_rem;
                        r_offset    <= w_new_off;
                        if (w_new_rem == '0 || w_abort) begin
                            r_state  <= S_IDLE;
                            r_blayer <= '0;
                            r_boff   <= '0;
                            r_blen   <= '0;
                        end else begin
                            r_state  <= S_ISSUE;
                            r_bvalid <= 1'b1;
                            r_boff   <= w_new_off;
                            r_blen   <= burst_min(w_new_rem, r_burst);
                        end
                    end else if (w_abort) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (burst_done) begin
                        r_remaining <= w_new_rem;
                        r_offset    <= w_new_off;
                        r_state     <= S_IDLE;
                        r_blayer    <= '0;
                        r_boff      <= '0;
                        r_blen      <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef DMA_SEQ_IRQ_EN
    logic r_irq_en;

    // Interrupt enable, writable at any time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_irq_en <= 1'b0;
        else if (csr_wen && w_sel_ctrl) r_irq_en <= csr_wdata[CTRL_IRQ_EN_BIT];
    end

    assign w_irq_en = r_irq_en;
    assign irq      = r_irq_en & (r_done | r_err);
`else
    assign w_irq_en = 1'b0;
    assign irq      = 1'b0;
`endif

    // Combinational CSR read mux; unmapped addresses read zero.
    always_comb begin
        w_rdata32 = '0;
        if (w_sel_layer) begin
            w_rdata32[7:0] = r_layer;
        end else if (w_sel_ctrl) begin
            w_rdata32[CTRL_IRQ_EN_BIT] = w_irq_en;
        end else if (w_sel_count) begin
            w_rdata32[15:0] = r_count;
        end else if (w_sel_status) begin
            w_rdata32[STAT_BUSY_BIT]         = w_busy;
            w_rdata32[STAT_DONE_BIT]         = r_done;
            w_rdata32[STAT_ERR_BIT]          = r_err;
            w_rdata32[STAT_REM_LSB +: 16]    = r_remaining;
        end else if (w_sel_burst) begin
            w_rdata32[7:0] = r_burst;
        end
    end

    assign csr_rdata    = CSR_DATA_WIDTH'(w_rdata32);
    assign burst_valid  = r_bvalid;
    assign burst_layer  = r_blayer;
    assign burst_offset = r_boff;
    assign burst_len    = r_blen;

endmodule

// File: tb/tb_dma_burst_seq.sv
// Directed self-checking bench for dma_burst_seq.
module tb_dma_burst_seq;
    import dma_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [7:0]  csr_addr;
    logic        csr_wen;
    logic        csr_ren;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        burst_valid;
    logic        burst_ready;
    logic [7:0]  burst_layer;
    logic [15:0] burst_offset;
    logic [7:0]  burst_len;
    logic        burst_done;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;

    dma_burst_seq #(.CSR_ADDR_WIDTH(8), .CSR_DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .csr_addr(csr_addr), .csr_wen(csr_wen), .csr_ren(csr_ren),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .burst_valid(burst_valid), .burst_ready(burst_ready),
        .burst_layer(burst_layer), .burst_offset(burst_offset),
        .burst_len(burst_len), .burst_done(burst_done), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [7:0] a, input logic [31:0] d);
        csr_addr  = a;
        csr_wdata = d;
        csr_wen   = 1'b1;
        tick();
        csr_wen   = 1'b0;
        csr_wdata = '0;
    endtask

    task automatic csr_read(input logic [7:0] a, output logic [31:0] d);
        csr_addr = a;
        csr_ren  = 1'b1;
        #1;
        d        = csr_rdata;
        csr_ren  = 1'b0;
    endtask

    // Checks the pending request (optionally across a stall), then accepts it
    // and completes it with a one-cycle burst_done.
    task automatic do_burst(input logic [7:0] lay, input logic [7:0] len,
                            input logic [15:0] off, input logic [15:0] rem,
                            input int stall);
        logic [31:0] s;
        for (int i = 0; i < stall; i++) begin
            check("stall_valid",  {31'd0, burst_valid}, 32'd1);
            check("stall_layer",  {24'd0, burst_layer}, {24'd0, lay});
            check("stall_offset", {16'd0, burst_offset}, {16'd0, off});
            check("stall_len",    {24'd0, burst_len}, {24'd0, len});
            tick();
        end
        check("req_valid",  {31'd0, burst_valid}, 32'd1);
        check("req_layer",  {24'd0, burst_layer}, {24'd0, lay});
        check("req_offset", {16'd0, burst_offset}, {16'd0, off});
        check("req_len",    {24'd0, burst_len}, {24'd0, len});
        csr_read(ADDR_STATUS, s);
        check("req_status", s, {rem, 16'h0001});
        burst_ready = 1'b1;
        tick();
        burst_ready = 1'b0;
        check("wait_valid", {31'd0, burst_valid}, 32'd0);
        burst_done = 1'b1;
        tick();
        burst_done = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; csr_addr = '0; csr_wen = 1'b0; csr_ren = 1'b0;
        csr_wdata = '0; burst_ready = 1'b0; burst_done = 1'b0;

        // Reset state
        #12;
        check("rst_valid",  {31'd0, burst_valid}, 32'd0);
        check("rst_outs",   {burst_layer, burst_offset, burst_len}, 32'd0);
        check("rst_irq",    {31'd0, irq}, 32'd0);
        csr_read(ADDR_STATUS, rd); check("rst_status", rd, 32'd0);
        csr_read(ADDR_COUNT, rd);  check("rst_count", rd, 32'd0);
        rst_n = 1'b1;
        tick();

        // Three-burst transfer with a 5-cycle stall on the second request
        csr_write(ADDR_LAYER, 32'd3);
        csr_write(ADDR_COUNT, 32'd10);
        csr_write(ADDR_BURST, 32'd4);
        csr_write(ADDR_CTRL,  32'h4);
        csr_read(ADDR_CTRL, rd);
`ifdef DMA_SEQ_IRQ_EN
        check("ctrl_irq_en", rd, 32'h4);
`else
        check("ctrl_irq_en", rd, 32'h0);
`endif
        csr_write(ADDR_CTRL, 32'h5);
        do_burst(8'd3, 8'd4, 16'd0, 16'd10, 0);
        do_burst(8'd3, 8'd4, 16'd4, 16'd6, 5);
        do_burst(8'd3, 8'd2, 16'd8, 16'd2, 0);
        csr_read(ADDR_STATUS, rd); check("xfer_done_status", rd, 32'h0000_0002);
        check("xfer_idle_valid", {31'd0, burst_valid}, 32'd0);
`ifdef DMA_SEQ_IRQ_EN
        check("irq_on_done", {31'd0, irq}, 32'd1);
`else
        check("irq_on_done", {31'd0, irq}, 32'd0);
`endif
        csr_write(ADDR_STATUS, 32'h2);
        check("irq_after_w1c", {31'd0, irq}, 32'd0);
        csr_read(ADDR_STATUS, rd); check("w1c_done_status", rd, 32'h0);

        // Abort during WAIT; busy-time COUNT write ignored
        csr_write(ADDR_LAYER, 32'd7);
        csr_write(ADDR_BURST, 32'd8);
        csr_write(ADDR_COUNT, 32'd20);
        csr_write(ADDR_CTRL,  32'h1);
        check("ab_len", {24'd0, burst_len}, 32'd8);
        csr_write(ADDR_COUNT, 32'h20);
        csr_read(ADDR_COUNT, rd); check("busy_count_wr", rd, 32'd20);
        burst_ready = 1'b1; tick(); burst_ready = 1'b0;
        csr_write(ADDR_CTRL, 32'h2);
        tick(); tick();
        csr_read(ADDR_STATUS, rd); check("drain_busy", rd, 32'h0014_0001);
        burst_done = 1'b1; tick(); burst_done = 1'b0;
        csr_read(ADDR_STATUS, rd); check("drain_end", rd, 32'h000C_0004);
        check("drain_valid", {31'd0, burst_valid}, 32'd0);
        csr_write(ADDR_STATUS, 32'h4);
        csr_read(ADDR_STATUS, rd); check("w1c_err", rd, 32'h000C_0000);

        // Abort during ISSUE; short final burst (remaining < BURST)
        csr_write(ADDR_COUNT, 32'd3);
        csr_write(ADDR_BURST, 32'd4);
        csr_write(ADDR_CTRL,  32'h1);
        check("short_len", {24'd0, burst_len}, 32'd3);
        csr_write(ADDR_CTRL, 32'h2);
        check("issue_abort_valid", {31'd0, burst_valid}, 32'd0);
        csr_read(ADDR_STATUS, rd); check("issue_abort_status", rd, 32'h0003_0004);

        // START+ABORT together, ABORT in IDLE, stray burst_done: all no-ops
        csr_write(ADDR_CTRL, 32'h3);
        tick();
        check("st_ab_valid", {31'd0, burst_valid}, 32'd0);
        csr_read(ADDR_STATUS, rd); check("st_ab_status", rd, 32'h0003_0004);
        burst_done = 1'b1; tick(); burst_done = 1'b0;
        csr_read(ADDR_STATUS, rd); check("stray_done", rd, 32'h0003_0004);

        // Set-wins: W1C ERR in the cycle DRAIN completes
        csr_write(ADDR_CTRL, 32'h1);
        burst_ready = 1'b1; tick(); burst_ready = 1'b0;
        csr_write(ADDR_CTRL, 32'h2);
        burst_done = 1'b1;
        csr_write(ADDR_STATUS, 32'h4);
        burst_done = 1'b0;
        csr_read(ADDR_STATUS, rd); check("set_wins", rd, 32'h0000_0004);
        csr_write(ADDR_STATUS, 32'h4);

        // Zero COUNT / zero BURST start errors
        csr_write(ADDR_COUNT, 32'd0);
        csr_write(ADDR_CTRL,  32'h1);
        check("cnt0_valid", {31'd0, burst_valid}, 32'd0);
        csr_read(ADDR_STATUS, rd); check("cnt0_status", rd, 32'h0000_0004);
        csr_write(ADDR_STATUS, 32'h4);
        csr_write(ADDR_COUNT, 32'd5);
        csr_write(ADDR_BURST, 32'd0);
        csr_write(ADDR_CTRL,  32'h1);
        tick();
        check("bst0_valid", {31'd0, burst_valid}, 32'd0);
        csr_read(ADDR_STATUS, rd); check("bst0_status", rd, 32'h0000_0004);

        // Asynchronous reset mid-ISSUE
        csr_write(ADDR_STATUS, 32'h4);
        csr_write(ADDR_LAYER, 32'd3);
        csr_write(ADDR_COUNT, 32'd10);
        csr_write(ADDR_BURST, 32'd4);
        csr_write(ADDR_CTRL,  32'h1);
        check("pre_rst_valid", {31'd0, burst_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_valid", {31'd0, burst_valid}, 32'd0);
        check("async_outs",  {burst_layer, burst_offset, burst_len}, 32'd0);
        check("async_irq",   {31'd0, irq}, 32'd0);
        csr_read(ADDR_STATUS, rd); check("async_status", rd, 32'd0);
        csr_read(ADDR_LAYER, rd);  check("async_layer", rd, 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", {31'd0, burst_valid}, 32'd0);
        csr_read(ADDR_STATUS, rd); check("post_rst_status", rd, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
